// File: rtl/branch_rs.sv
// Branch reservation station: buffers dispatched branch/jump ops, snoops three CDBs for
// missing operands and issues the lowest-index ready entry as registered operands.
module branch_rs #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned OP_W  = 6,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [XLEN-1:0]  disp_v1,
  input  logic [XLEN-1:0]  disp_v2,
  input  logic [TAG_W-1:0] disp_q1,
  input  logic [TAG_W-1:0] disp_q2,
  input  logic             disp_r1,
  input  logic             disp_r2,
  input  logic [TAG_W-1:0] disp_dest,
  input  logic [XLEN-1:0]  disp_imm,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic             cdb0_valid,
  input  logic [TAG_W-1:0] cdb0_tag,
  input  logic [XLEN-1:0]  cdb0_data,
  input  logic             cdb1_valid,
  input  logic [TAG_W-1:0] cdb1_tag,
  input  logic [XLEN-1:0]  cdb1_data,
  input  logic             cdb2_valid,
  input  logic [TAG_W-1:0] cdb2_tag,
  input  logic [XLEN-1:0]  cdb2_data,
  output logic             full_out,
  output logic             ex_enable,
  output logic [OP_W-1:0]  ex_op,
  output logic [XLEN-1:0]  ex_reg1,
  output logic [XLEN-1:0]  ex_reg2,
  output logic [TAG_W-1:0] ex_dest,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [DEPTH-1:0] busy_q, r1_q, r2_q;
  logic [OP_W-1:0]  op_q   [DEPTH];
  logic [XLEN-1:0]  v1_q   [DEPTH];
  logic [XLEN-1:0]  v2_q   [DEPTH];
  logic [XLEN-1:0]  imm_q  [DEPTH];
  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [TAG_W-1:0] q1_q   [DEPTH];
  logic [TAG_W-1:0] q2_q   [DEPTH];
  logic [TAG_W-1:0] dest_q [DEPTH];

  logic [2:0]       cdb_v;
  logic [TAG_W-1:0] cdb_t [3];
  logic [XLEN-1:0]  cdb_d [3];

  logic [DEPTH-1:0] hit1, hit2, ready;
  logic [XLEN-1:0]  dat1 [DEPTH];
  logic [XLEN-1:0]  dat2 [DEPTH];
  logic             dhit1, dhit2, disp_fire, issue_vld;
  logic [XLEN-1:0]  ddat1, ddat2;
  logic [IdxW-1:0]  free_idx, issue_idx;

  assign cdb_v    = {cdb2_valid, cdb1_valid, cdb0_valid};
  assign cdb_t[0] = cdb0_tag;
  assign cdb_t[1] = cdb1_tag;
  assign cdb_t[2] = cdb2_tag;
  assign cdb_d[0] = cdb0_data;
  assign cdb_d[1] = cdb1_data;
  assign cdb_d[2] = cdb2_data;

  assign ready     = busy_q & r1_q & r2_q;
  assign full_out  = &busy_q;
  assign disp_fire = disp_valid & ~full_out;

  // All buses carry the same value for a tag, so any match order is valid.
  always_comb begin
    dhit1 = 1'b0;
    dhit2 = 1'b0;
    ddat1 = '0;
    ddat2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = 1'b0;
      hit2[i] = 1'b0;
      dat1[i] = '0;
      dat2[i] = '0;
    end
    for (int k = 2; k >= 0; k--) begin
      if (cdb_v[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cdb_t[k] == q1_q[i]) begin
            hit1[i] = 1'b1;
            dat1[i] = cdb_d[k];
          end
          if (cdb_t[k] == q2_q[i]) begin
            hit2[i] = 1'b1;
            dat2[i] = cdb_d[k];
          end
        end
        if (cdb_t[k] == disp_q1) begin
          dhit1 = 1'b1;
          ddat1 = cdb_d[k];
        end
        if (cdb_t[k] == disp_q2) begin
          dhit2 = 1'b1;
          ddat2 = cdb_d[k];
        end
      end
    end
  end

  // Descending scan leaves the lowest matching index selected.
  always_comb begin
    free_idx  = '0;
    issue_idx = '0;
    issue_vld = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IdxW'(i);
      if (ready[i]) begin
        issue_idx = IdxW'(i);
        issue_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q    <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
        imm_q[i]  <= '0;
        pc_q[i]   <= '0;
        q1_q[i]   <= '0;
        q2_q[i]   <= '0;
        dest_q[i] <= '0;
      end
      ex_enable <= 1'b0;
      ex_op     <= '0;
      ex_reg1   <= '0;
      ex_reg2   <= '0;
      ex_dest   <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        busy_q    <= '0;
        ex_enable <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy_q[i] && !r1_q[i] && hit1[i]) begin
            v1_q[i] <= dat1[i];
            r1_q[i] <= 1'b1;
          end
          if (busy_q[i] && !r2_q[i] && hit2[i]) begin
            v2_q[i] <= dat2[i];
            r2_q[i] <= 1'b1;
          end
        end
        ex_enable <= issue_vld;
        if (issue_vld) begin
          ex_op             <= op_q[issue_idx];
          ex_reg1           <= v1_q[issue_idx];
          ex_reg2           <= v2_q[issue_idx];
          ex_dest           <= dest_q[issue_idx];
          ex_imm            <= imm_q[issue_idx];
          ex_pc             <= pc_q[issue_idx];
          busy_q[issue_idx] <= 1'b0;
        end
        // free_idx is never busy, so it cannot collide with issue_idx.
        if (disp_fire) begin
          busy_q[free_idx] <= 1'b1;
          op_q[free_idx]   <= disp_op;
          v1_q[free_idx]   <= (!disp_r1 && dhit1) ? ddat1 : disp_v1;
          v2_q[free_idx]   <= (!disp_r2 && dhit2) ? ddat2 : disp_v2;
          r1_q[free_idx]   <= disp_r1 | dhit1;
          r2_q[free_idx]   <= disp_r2 | dhit2;
          q1_q[free_idx]   <= disp_q1;
          q2_q[free_idx]   <= disp_q2;
          dest_q[free_idx] <= disp_dest;
          imm_q[free_idx]  <= disp_imm;
          pc_q[free_idx]   <= disp_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
// Self-checking bench for branch_rs: vector table plus hand-written sequences, with a
// scoreboard of expected issues stamped with the cycle they must appear in.
module tb_branch_rs;

  localparam logic [5:0] OP_BEQ  = 6'd1;
  localparam logic [5:0] OP_BNE  = 6'd2;
  localparam logic [5:0] OP_BLT  = 6'd3;
  localparam logic [5:0] OP_BGE  = 6'd4;
  localparam logic [5:0] OP_BLTU = 6'd5;
  localparam logic [5:0] OP_JAL  = 6'd7;
  localparam logic [5:0] OP_JALR = 6'd8;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in, rdy_in, clear_in, disp_valid, disp_r1, disp_r2;
  logic [5:0]  disp_op;
  logic [31:0] disp_v1, disp_v2, disp_imm, disp_pc;
  logic [3:0]  disp_q1, disp_q2, disp_dest;
  logic        cdb0_valid, cdb1_valid, cdb2_valid;
  logic [3:0]  cdb0_tag, cdb1_tag, cdb2_tag;
  logic [31:0] cdb0_data, cdb1_data, cdb2_data;
  logic        full_out, ex_enable;
  logic [5:0]  ex_op;
  logic [31:0] ex_reg1, ex_reg2, ex_imm, ex_pc;
  logic [3:0]  ex_dest;

  branch_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_r1(disp_r1), .disp_r2(disp_r2),
    .disp_dest(disp_dest), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag), .cdb2_data(cdb2_data),
    .full_out(full_out), .ex_enable(ex_enable), .ex_op(ex_op), .ex_reg1(ex_reg1),
    .ex_reg2(ex_reg2), .ex_dest(ex_dest), .ex_imm(ex_imm), .ex_pc(ex_pc)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  dest;
    logic [31:0] imm;
    logic [31:0] pc;
  } pkt_t;

  typedef struct {
    pkt_t pkt;
    int   stamp;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] v1;
    logic [3:0]  q1;
    logic        r1;
    logic [31:0] v2;
    logic [3:0]  q2;
    logic        r2;
    logic [3:0]  dest;
    logic [31:0] imm;
    logic [31:0] pc;
    int          bus;
    logic [3:0]  ctag;
    logic [31:0] cdata;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;
  logic rdy_edge;
  pkt_t snap;

  function automatic pkt_t mk(input logic [5:0] op, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [3:0] dest,
                              input logic [31:0] imm, input logic [31:0] pc);
    mk = {op, r1, r2, dest, imm, pc};
  endfunction

  function automatic pkt_t actual();
    actual = {ex_op, ex_reg1, ex_reg2, ex_dest, ex_imm, ex_pc};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic push(input pkt_t p, input int stamp);
    exp_t e;
    e.pkt   = p;
    e.stamp = stamp;
    sb.push_back(e);
  endtask

  // Compares only on edges where the DUT was live, so frozen cycles are never popped.
  task automatic tick();
    exp_t e;
    rdy_edge = rdy_in && rst_in;
    @(posedge clk_in);
    #1;
    cyc++;
    if (rdy_edge && ex_enable) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_issue: got issue dest=%0h at cycle %0d, required none",
                 ex_dest, cyc);
      end else begin
        e = sb.pop_front();
        chk("issue_data", 160'(actual()), 160'(e.pkt));
        chk("issue_cycle", 160'(cyc), 160'(e.stamp));
      end
    end else if (rdy_edge && sb.size() > 0 && sb[0].stamp <= cyc) begin
      e = sb.pop_front();
      n_tot++;
      $display("FAIL missing_issue: got ex_enable=0 at cycle %0d, required issue dest=%0h",
               cyc, e.pkt.dest);
    end
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    clear_in   = 1'b0;
    cdb0_valid = 1'b0;
    cdb1_valid = 1'b0;
    cdb2_valid = 1'b0;
  endtask

  task automatic drive_disp(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] q1,
                            input logic r1, input logic [31:0] v2, input logic [3:0] q2,
                            input logic r2, input logic [3:0] dest, input logic [31:0] imm,
                            input logic [31:0] pc);
    disp_valid = 1'b1;
    disp_op    = op;
    disp_v1    = v1;
    disp_q1    = q1;
    disp_r1    = r1;
    disp_v2    = v2;
    disp_q2    = q2;
    disp_r2    = r2;
    disp_dest  = dest;
    disp_imm   = imm;
    disp_pc    = pc;
  endtask

  task automatic set_cdb(input int bus, input logic [3:0] tag, input logic [31:0] data);
    case (bus)
      0: begin cdb0_valid = 1'b1; cdb0_tag = tag; cdb0_data = data; end
      1: begin cdb1_valid = 1'b1; cdb1_tag = tag; cdb1_data = data; end
      2: begin cdb2_valid = 1'b1; cdb2_tag = tag; cdb2_data = data; end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{OP_BNE, 32'h11, 4'd0, 1'b1, 32'h0, 4'd4, 1'b0, 4'd1, 32'h10, 32'h200,
                1, 4'd4, 32'h9, 32'h11, 32'h9};
    vecs[1] = '{OP_BLT, 32'h0, 4'd7, 1'b0, 32'h22, 4'd0, 1'b1, 4'd2, 32'hFFFF_FFF0, 32'h204,
                0, 4'd7, 32'h70, 32'h70, 32'h22};
    vecs[2] = '{OP_BGE, 32'h0, 4'd9, 1'b0, 32'h0, 4'd9, 1'b0, 4'd3, 32'h20, 32'h208,
                2, 4'd9, 32'h99, 32'h99, 32'h99};
    vecs[3] = '{OP_BLTU, 32'h1, 4'd5, 1'b1, 32'h2, 4'd5, 1'b1, 4'd4, 32'h4, 32'h20C,
                0, 4'd5, 32'hDEAD, 32'h1, 32'h2};
    vecs[4] = '{OP_JAL, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 4'd5, 32'h800, 32'h2000,
                3, 4'd0, 32'h0, 32'h0, 32'h0};
    vecs[5] = '{OP_JALR, 32'h3000, 4'd3, 1'b1, 32'h0, 4'd0, 1'b1, 4'd6, 32'h4, 32'h2004,
                1, 4'd3, 32'h55, 32'h3000, 32'h0};

    rst_in = 1'b0;
    rdy_in = 1'b1;
    idle();
    drive_disp(OP_BEQ, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    disp_valid = 1'b0;
    cdb0_tag = '0; cdb1_tag = '0; cdb2_tag = '0;
    cdb0_data = '0; cdb1_data = '0; cdb2_data = '0;
    #12;
    chk("reset_ex_enable", 160'(ex_enable), 160'(0));
    chk("reset_ex_fields", 160'(actual()), 160'(0));
    chk("reset_full", 160'(full_out), 160'(0));
    #2 rst_in = 1'b1;
    tick();

    // Ready-at-dispatch op issues next cycle, then ex_enable drops.
    drive_disp(OP_BEQ, 5, 0, 1, 5, 0, 1, 4'd1, 32'h8, 32'h100);
    push(mk(OP_BEQ, 5, 5, 4'd1, 32'h8, 32'h100), cyc + 2);
    tick();
    idle();
    tick();
    tick();
    chk("t1_enable_drop", 160'(ex_enable), 160'(0));

    // CDB wakeup two cycles after dispatch; a wrong-tag broadcast precedes it.
    drive_disp(OP_BNE, 0, 4'd3, 0, 32'h11, 0, 1, 4'd2, 32'h10, 32'h104);
    tick();
    idle();
    set_cdb(0, 4'd5, 32'h66);
    tick();
    idle();
    set_cdb(0, 4'd3, 32'h7);
    push(mk(OP_BNE, 32'h7, 32'h11, 4'd2, 32'h10, 32'h104), cyc + 2);
    tick();
    idle();
    tick();
    tick();

    for (int i = 0; i < 6; i++) begin
      idle();
      drive_disp(vecs[i].op, vecs[i].v1, vecs[i].q1, vecs[i].r1, vecs[i].v2, vecs[i].q2,
                 vecs[i].r2, vecs[i].dest, vecs[i].imm, vecs[i].pc);
      set_cdb(vecs[i].bus, vecs[i].ctag, vecs[i].cdata);
      push(mk(vecs[i].op, vecs[i].e1, vecs[i].e2, vecs[i].dest, vecs[i].imm, vecs[i].pc),
           cyc + 2);
      tick();
    end
    idle();
    tick();
    tick();

    // Fill every entry waiting on tag 2, drop an extra dispatch, then drain in index order.
    for (int i = 0; i < 8; i++) begin
      drive_disp(OP_BEQ, 0, 4'd2, 0, 32'h40 + i, 0, 1, 4'(i), 32'(i * 4), 32'h400 + i * 4);
      tick();
      if (i == 6) chk("t4_not_full_at_7", 160'(full_out), 160'(0));
    end
    chk("t4_full", 160'(full_out), 160'(1));
    drive_disp(OP_JAL, 0, 0, 1, 0, 0, 1, 4'd15, 32'h0, 32'hBAD);
    tick();
    chk("t4_full_after_drop", 160'(full_out), 160'(1));
    idle();
    set_cdb(2, 4'd2, 32'hAA);
    for (int i = 0; i < 8; i++)
      push(mk(OP_BEQ, 32'hAA, 32'h40 + i, 4'(i), 32'(i * 4), 32'h400 + i * 4), cyc + 2 + i);
    tick();
    idle();
    tick();
    chk("t4_full_released", 160'(full_out), 160'(0));
    for (int i = 0; i < 8; i++) tick();

    // Clear wins over a pending issue and a same-cycle dispatch.
    drive_disp(OP_BEQ, 0, 4'd6, 0, 1, 0, 1, 4'd1, 0, 32'h500);
    tick();
    drive_disp(OP_BEQ, 0, 4'd6, 0, 2, 0, 1, 4'd2, 0, 32'h504);
    tick();
    drive_disp(OP_BNE, 3, 0, 1, 3, 0, 1, 4'd3, 0, 32'h508);
    tick();
    clear_in = 1'b1;
    drive_disp(OP_BNE, 4, 0, 1, 4, 0, 1, 4'd4, 0, 32'h50C);
    tick();
    chk("t5_clear_enable", 160'(ex_enable), 160'(0));
    chk("t5_clear_full", 160'(full_out), 160'(0));
    idle();
    set_cdb(1, 4'd6, 32'h60);
    tick();
    idle();
    tick();
    chk("t5_no_issue_after_wake", 160'(ex_enable), 160'(0));
    tick();

    // Freeze with rdy_in low: outputs hold, dispatch ignored, then B issues on resume.
    drive_disp(OP_BLT, 32'h31, 0, 1, 32'h32, 0, 1, 4'd3, 32'hC, 32'h600);
    push(mk(OP_BLT, 32'h31, 32'h32, 4'd3, 32'hC, 32'h600), cyc + 2);
    snap = mk(OP_BLT, 32'h31, 32'h32, 4'd3, 32'hC, 32'h600);
    tick();
    drive_disp(OP_BGE, 32'h41, 0, 1, 32'h42, 0, 1, 4'd4, 32'h10, 32'h604);
    push(mk(OP_BGE, 32'h41, 32'h42, 4'd4, 32'h10, 32'h604), cyc + 5);
    tick();
    rdy_in = 1'b0;
    drive_disp(OP_BNE, 32'h51, 0, 1, 32'h52, 0, 1, 4'd5, 32'h14, 32'h608);
    set_cdb(0, 4'd1, 32'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_frozen_enable", 160'(ex_enable), 160'(1));
      chk("t6_frozen_fields", 160'(actual()), 160'(snap));
    end
    idle();
    rdy_in = 1'b1;
    tick();
    tick();
    chk("t6_resume_idle", 160'(ex_enable), 160'(0));

    // Asynchronous reset while an issue is on the outputs and an entry is waiting.
    drive_disp(OP_BEQ, 32'h61, 0, 1, 32'h62, 0, 1, 4'd6, 32'h18, 32'h700);
    push(mk(OP_BEQ, 32'h61, 32'h62, 4'd6, 32'h18, 32'h700), cyc + 2);
    tick();
    drive_disp(OP_BEQ, 0, 4'd9, 0, 32'h72, 0, 1, 4'd7, 32'h1C, 32'h704);
    tick();
    idle();
    #2 rst_in = 1'b0;
    #1;
    chk("t6_async_enable", 160'(ex_enable), 160'(0));
    chk("t6_async_fields", 160'(actual()), 160'(0));
    #2 rst_in = 1'b1;
    set_cdb(0, 4'd9, 32'h5);
    tick();
    idle();
    tick();
    tick();
    chk("t6_post_reset_idle", 160'(ex_enable), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
